mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter at the CPU data-bus side; consumes the core's SW stores to the UART window (default 0x3000_0000).
- Buffers written bytes in a small FIFO and serializes them 8N1, LSB first, on a single TX pin.
- Provides a readable status register so firmware can poll instead of relying on fixed delays.

---
 rtl/mmio_uart_tx.sv | 210 +++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter (8N1, LSB first).
// Stores to TXDATA are queued in a small FIFO and serialized on uart_tx.
// STATUS reports busy / fifo_full / fifo_empty / sticky overflow (W1C).
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit (8E1).
module mmio_uart_tx #(
  parameter int          CLK_HZ     = 50_000_000,
  parameter int          BAUD       = 115_200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  input  logic        bus_re,
  output logic [31:0] bus_rdata,
  output logic        uart_tx,
  output logic        tx_irq
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int AW  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [AW:0]   FULL_CT = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  // Address decode
  logic       hit;
  logic [1:0] reg_sel;
  logic       wr_txdata;
  logic       wr_status;
  logic       rd_status;

  assign hit       = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_sel   = bus_addr[3:2];
  assign wr_txdata = hit & bus_we & (reg_sel == 2'd0);
  assign wr_status = hit & bus_we & (reg_sel == 2'd1);
  assign rd_status = hit & bus_re & (reg_sel == 2'd1);

  // State
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          uart_tx_q, uart_tx_d;

  logic fifo_empty;
  logic fifo_full;
  logic busy;
  logic push;
  logic pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CT);
  assign busy       = (state_q != S_IDLE);

  // A write to a full FIFO is still accepted when the FSM pops on the same edge.
  assign push = wr_txdata & (~fifo_full | pop);

  // Only the low byte of data and word-aligned addresses are meaningful
  logic unused_bits;
  assign unused_bits = ^{bus_wdata[31:8], bus_wdata[2:0], bus_wdata[7:4], bus_addr[1:0]};

  // FIFO pointers, occupancy and sticky overflow flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    if (wr_status && bus_wdata[3]) ovf_d = 1'b0;
    // set has priority over a coincident clear
    if (wr_txdata && !push) ovf_d = 1'b1;
  end

  // Transmit FSM: baud counter, bit index and shift register
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
          cnt_d   = DIV_M1;
        end
      end
      S_START, S_DATA, S_STOP
`ifdef UART_TX_PARITY_EN
      , S_PARITY
`endif
      : begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          cnt_d = DIV_M1;
          case (state_q)
            S_START: begin
              state_d = S_DATA;
              idx_d   = 3'd0;
            end
            S_DATA: begin
              if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                state_d = S_PARITY;
`else
                state_d = S_STOP;
`endif
              end else begin
                idx_d = idx_q + 3'd1;
              end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: state_d = S_STOP;
`endif
            default: begin
              // end of stop bit: chain straight into the next frame if data is queued
              if (!fifo_empty) begin
                pop     = 1'b1;
                shift_d = mem_q[rd_ptr_q];
                state_d = S_START;
              end else begin
                state_d = S_IDLE;
              end
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level follows the next state so it is registered yet starts one edge after the store.
  always_comb begin
    uart_tx_d = 1'b1;
    case (state_d)
      S_START: uart_tx_d = 1'b0;
      S_DATA:  uart_tx_d = shift_d[idx_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: uart_tx_d = ^shift_d;
`endif
      default: uart_tx_d = 1'b1;
    endcase
  end

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus_wdata[7:0];
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      uart_tx_q <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      uart_tx_q <= uart_tx_d;
    end
  end

  // Outputs
  always_comb begin
    bus_rdata = '0;
    if (rd_status) bus_rdata = {28'h0, ovf_q, fifo_empty, fifo_full, busy};
  end

  assign uart_tx = uart_tx_q;
  assign tx_irq  = fifo_empty & ~busy;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench for mmio_uart_tx (DIV=10).
// dut4 uses FIFO_DEPTH=4, dut16 uses FIFO_DEPTH=16 for the message stream.
module tb_mmio_uart_tx;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR   = 1'b0;
`endif
  localparam int FRAME = NBITS * DIV;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] STATUS = 32'h3000_0004;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic        sel16 = 1'b0;

  logic        we4, re4, we16, re16;
  logic [31:0] rdata4, rdata16;
  logic        tx4, tx16, irq4, irq16;

  int checks = 0;
  int failures = 0;

  assign we4  = bus_we & ~sel16;
  assign re4  = bus_re & ~sel16;
  assign we16 = bus_we & sel16;
  assign re16 = bus_re & sel16;

  always #5 clk = ~clk;

  mmio_uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(4), .BASE_ADDR(BASE)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(we4), .bus_re(re4), .bus_rdata(rdata4), .uart_tx(tx4), .tx_irq(irq4)
  );

  mmio_uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(16), .BASE_ADDR(BASE)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(we16), .bus_re(re16), .bus_rdata(rdata16), .uart_tx(tx16), .tx_irq(irq16)
  );

  // Expected line waveform for one frame, one entry per clock: start, d[0..7], (parity), stop
  function automatic logic [FRAME-1:0] frame_of(input logic [7:0] d);
    logic [FRAME-1:0] v;
    int b;
    v = '1;
    for (int k = 0; k < FRAME; k++) begin
      b = k / DIV;
      if (b == 0)                v[k] = 1'b0;
      else if (b <= 8)           v[k] = d[b-1];
      else if (PAR && (b == 9))  v[k] = ^d;
      else                       v[k] = 1'b1;
    end
    return v;
  endfunction

  // One-cycle store; call right after a negedge, returns at the next negedge
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    @(negedge clk);
    bus_we    = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx4 !== 1'b1 || irq4 !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs: uart_tx=%b tx_irq=%b, required 1 1", tx4, irq4);
    end
    rst_n = 1'b1;
    @(negedge clk);
    bus_addr = STATUS;
    bus_re   = 1'b1;
    #1;
    checks++;
    if (rdata4 !== 32'h4) begin
      failures++;
      $display("FAIL reset_status4: got %h, required 00000004", rdata4);
    end
    sel16 = 1'b1;
    #1;
    checks++;
    if (rdata16 !== 32'h4 || tx16 !== 1'b1 || irq16 !== 1'b1) begin
      failures++;
      $display("FAIL reset_status16: status=%h tx=%b irq=%b, required 00000004 1 1", rdata16, tx16, irq16);
    end
    sel16  = 1'b0;
    bus_re = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame(input string name, input logic [7:0] d);
    logic [FRAME-1:0] obs, obs_busy, obs_irq;
    sel16 = 1'b0;
    bus_write(BASE, {24'h0, d});
    checks++;
    if (tx4 !== 1'b1) begin
      failures++;
      $display("FAIL %s_latency: uart_tx=%b on write edge, required 1", name, tx4);
    end
    bus_addr = STATUS;
    bus_re   = 1'b1;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      obs[k]      = tx4;
      obs_busy[k] = rdata4[0];
      obs_irq[k]  = irq4;
    end
    checks++;
    if (obs !== frame_of(d)) begin
      failures++;
      $display("FAIL %s_line: got %h, required %h", name, obs, frame_of(d));
    end
    checks++;
    if (obs_busy !== '1 || obs_irq !== '0) begin
      failures++;
      $display("FAIL %s_busy_irq: busy=%h irq=%h, required all ones / all zeros", name, obs_busy, obs_irq);
    end
    @(negedge clk);
    checks++;
    if (tx4 !== 1'b1 || irq4 !== 1'b1 || rdata4 !== 32'h4) begin
      failures++;
      $display("FAIL %s_end: tx=%b irq=%b status=%h, required 1 1 00000004", name, tx4, irq4, rdata4);
    end
    bus_re = 1'b0;
  endtask

  task automatic test_cpu_ok;
    logic [7:0]       msg [8];
    logic [FRAME-1:0] obs [8];
    msg = '{8'h43, 8'h50, 8'h55, 8'h20, 8'h4F, 8'h4B, 8'h0D, 8'h0A};
    sel16 = 1'b1;
    bus_addr = BASE;
    for (int c = 0; c <= 8 * FRAME; c++) begin
      if (c < 16 && (c % 2) == 0) begin
        bus_wdata = {24'h0, msg[c/2]};
        bus_we    = 1'b1;
      end else begin
        bus_we = 1'b0;
      end
      @(negedge clk);
      if (c >= 1) obs[(c-1)/FRAME][(c-1)%FRAME] = tx16;
    end
    for (int f = 0; f < 8; f++) begin
      checks++;
      if (obs[f] !== frame_of(msg[f])) begin
        failures++;
        $display("FAIL cpu_ok_frame%0d: got %h, required %h", f, obs[f], frame_of(msg[f]));
      end
    end
    bus_addr = STATUS;
    bus_re   = 1'b1;
    @(negedge clk);
    checks++;
    if (rdata16 !== 32'h4 || tx16 !== 1'b1 || irq16 !== 1'b1) begin
      failures++;
      $display("FAIL cpu_ok_end: status=%h tx=%b irq=%b, required 00000004 1 1", rdata16, tx16, irq16);
    end
    bus_re = 1'b0;
    sel16  = 1'b0;
  endtask

  task automatic test_overflow;
    logic [7:0]       dat [8];
    logic [FRAME-1:0] obs [6];
    dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    sel16 = 1'b0;
    bus_addr = BASE;
    for (int c = 0; c <= 6 * FRAME; c++) begin
      if (c < 8) begin
        bus_wdata = {24'h0, dat[c]};
        bus_we    = 1'b1;
      end else begin
        bus_we = 1'b0;
      end
      @(negedge clk);
      if (c >= 1) obs[(c-1)/FRAME][(c-1)%FRAME] = tx4;
    end
    for (int f = 0; f < 5; f++) begin
      checks++;
      if (obs[f] !== frame_of(dat[f])) begin
        failures++;
        $display("FAIL overflow_frame%0d: got %h, required %h", f, obs[f], frame_of(dat[f]));
      end
    end
    checks++;
    if (obs[5] !== '1) begin
      failures++;
      $display("FAIL overflow_no_sixth: got %h, required idle high", obs[5]);
    end
    bus_addr = STATUS;
    bus_re   = 1'b1;
    #1;
    checks++;
    if (rdata4 !== 32'hC) begin
      failures++;
      $display("FAIL overflow_flag: status=%h, required 0000000c", rdata4);
    end
    bus_write(STATUS, 32'h7);
    #1;
    checks++;
    if (rdata4 !== 32'hC) begin
      failures++;
      $display("FAIL overflow_keep: status=%h, required 0000000c", rdata4);
    end
    bus_write(STATUS, 32'h8);
    #1;
    checks++;
    if (rdata4 !== 32'h4) begin
      failures++;
      $display("FAIL overflow_clear: status=%h, required 00000004", rdata4);
    end
    bus_re = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_decode;
    logic [3*DIV-1:0] obs;
    sel16 = 1'b0;
    bus_write(BASE + 32'h10, 32'h55);
    bus_write(BASE + 32'h8, 32'h55);
    for (int k = 0; k < 3 * DIV; k++) begin
      @(negedge clk);
      obs[k] = tx4;
    end
    checks++;
    if (obs !== '1) begin
      failures++;
      $display("FAIL decode_no_frame: line=%h, required all ones", obs);
    end
    bus_re = 1'b1;
    bus_addr = STATUS;
    #1;
    checks++;
    if (rdata4 !== 32'h4) begin
      failures++;
      $display("FAIL decode_status: got %h, required 00000004", rdata4);
    end
    bus_addr = BASE;
    #1;
    checks++;
    if (rdata4 !== 32'h0) begin
      failures++;
      $display("FAIL decode_txdata_read: got %h, required 00000000", rdata4);
    end
    bus_addr = BASE + 32'hC;
    #1;
    checks++;
    if (rdata4 !== 32'h0) begin
      failures++;
      $display("FAIL decode_reserved_read: got %h, required 00000000", rdata4);
    end
    bus_addr = BASE + 32'h14;
    #1;
    checks++;
    if (rdata4 !== 32'h0) begin
      failures++;
      $display("FAIL decode_miss_read: got %h, required 00000000", rdata4);
    end
    bus_addr = STATUS;
    bus_re   = 1'b0;
    #1;
    checks++;
    if (rdata4 !== 32'h0) begin
      failures++;
      $display("FAIL decode_no_re: got %h, required 00000000", rdata4);
    end
    // simultaneous store and load on STATUS are both serviced
    bus_re    = 1'b1;
    bus_wdata = 32'h0;
    bus_we    = 1'b1;
    #1;
    checks++;
    if (rdata4 !== 32'h4) begin
      failures++;
      $display("FAIL decode_we_re: got %h, required 00000004", rdata4);
    end
    @(negedge clk);
    bus_we = 1'b0;
    bus_re = 1'b0;
  endtask

  task automatic test_reset_midframe;
    logic [2*FRAME-1:0] obs;
    sel16 = 1'b0;
    bus_addr = BASE;
    // queue 0x43, 0x5A, 0x3C; stop inside data bit 4 of 0x43 (a zero)
    for (int c = 0; c <= 5 * DIV + 6; c++) begin
      if (c < 3) begin
        bus_wdata = (c == 0) ? 32'h43 : (c == 1) ? 32'h5A : 32'h3C;
        bus_we    = 1'b1;
      end else begin
        bus_we = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (tx4 !== 1'b0) begin
      failures++;
      $display("FAIL midframe_bit4: uart_tx=%b, required 0", tx4);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx4 !== 1'b1 || irq4 !== 1'b1) begin
      failures++;
      $display("FAIL midframe_async: tx=%b irq=%b, required 1 1", tx4, irq4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      obs[k] = tx4;
    end
    checks++;
    if (obs !== '1) begin
      failures++;
      $display("FAIL midframe_discard: line=%h, required all ones", obs);
    end
    bus_addr = STATUS;
    bus_re   = 1'b1;
    #1;
    checks++;
    if (rdata4 !== 32'h4) begin
      failures++;
      $display("FAIL midframe_status: got %h, required 00000004", rdata4);
    end
    bus_re = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_frame("single_43", 8'h43);
    test_cpu_ok();
    test_overflow();
    test_decode();
    test_reset_midframe();
    test_frame("parity_03", 8'h03);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
